// File: rtl/sram_axil_pkg.sv
// Shared types and constants for the AXI4-Lite to single-port SRAM controller.
package sram_axil_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_EXEC,
      ST_WR_RESP,
      ST_RD_EXEC,
      ST_RD_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/sram_axil_ctrl.sv
// AXI4-Lite slave that turns one read or write at a time into a single-cycle
// SRAM access strobe, alternating read/write priority when both compete.
module sram_axil_ctrl
   import sram_axil_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 64,
   parameter int STRB_WIDTH      = 8,
   parameter int RAM_INDEX_WIDTH = 9,
   parameter int SRAM_DEPTH      = 512
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [ADDR_WIDTH-1:0]      s_awaddr,
   input  logic                       s_awvalid,
   output logic                       s_awready,
   input  logic [DATA_WIDTH-1:0]      s_wdata,
   input  logic [STRB_WIDTH-1:0]      s_wstrb,
   input  logic                       s_wvalid,
   output logic                       s_wready,
   output logic [1:0]                 s_bresp,
   output logic                       s_bvalid,
   input  logic                       s_bready,
   input  logic [ADDR_WIDTH-1:0]      s_araddr,
   input  logic                       s_arvalid,
   output logic                       s_arready,
   output logic [DATA_WIDTH-1:0]      s_rdata,
   output logic [1:0]                 s_rresp,
   output logic                       s_rvalid,
   input  logic                       s_rready,
   output logic                       sram_chip_en_o,
   output logic                       sram_wr_en_o,
   output logic                       sram_rd_en_o,
   output logic [RAM_INDEX_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0]      sram_wr_data_o,
   output logic                       sram_wr_mask_en_o,
   output logic [STRB_WIDTH-1:0]      sram_wr_mask_o,
   input  logic [DATA_WIDTH-1:0]      sram_rd_data_i
);

   localparam int BYTE_BITS = $clog2(STRB_WIDTH);

   function automatic logic addr_decerr(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] word;
      word = addr >> BYTE_BITS;
      return word >= ADDR_WIDTH'(SRAM_DEPTH);
   endfunction

   function automatic logic [RAM_INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
      return RAM_INDEX_WIDTH'(addr >> BYTE_BITS);
   endfunction

   state_t                state, state_nxt;
   logic                  ready_en;
   logic                  last_wr;
   logic                  aw_cap, w_cap;
   logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
   logic [DATA_WIDTH-1:0] w_data, rdata;
   logic [STRB_WIDTH-1:0] w_strb;
   logic [1:0]            bresp, rresp;

   logic in_idle, wr_pend, wr_req;
   logic ar_rdy, rd_grant, aw_rdy, w_rdy;
   logic ar_hs, aw_hs, w_hs, wr_go;
   logic wr_err, rd_err, wr_strobe, rd_strobe;

   // A captured write half commits the write; otherwise read wins only if write was served last.
   assign in_idle  = ready_en && (state == ST_IDLE);
   assign wr_pend  = aw_cap | w_cap;
   assign wr_req   = s_awvalid | s_wvalid;
   assign ar_rdy   = in_idle && !wr_pend && (!wr_req || last_wr);
   assign rd_grant = ar_rdy && s_arvalid;
   assign aw_rdy   = in_idle && !aw_cap && !rd_grant;
   assign w_rdy    = in_idle && !w_cap && !rd_grant;

   assign ar_hs = ar_rdy && s_arvalid;
   assign aw_hs = aw_rdy && s_awvalid;
   assign w_hs  = w_rdy && s_wvalid;
   assign wr_go = (aw_cap || aw_hs) && (w_cap || w_hs);

   assign wr_err    = addr_decerr(aw_addr);
   assign rd_err    = addr_decerr(ar_addr);
   assign wr_strobe = (state == ST_WR_EXEC) && !wr_err && (w_strb != '0);
   assign rd_strobe = (state == ST_RD_EXEC) && !rd_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (ar_hs)      state_nxt = ST_RD_EXEC;
            else if (wr_go) state_nxt = ST_WR_EXEC;
         end
         ST_WR_EXEC: state_nxt = ST_WR_RESP;
         ST_WR_RESP: if (s_bready) state_nxt = ST_IDLE;
         ST_RD_EXEC: state_nxt = ST_RD_RESP;
         ST_RD_RESP: if (s_rready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_arready         = ar_rdy;
      s_awready         = aw_rdy;
      s_wready          = w_rdy;
      s_bvalid          = (state == ST_WR_RESP);
      s_rvalid          = (state == ST_RD_RESP);
      sram_wr_en_o      = 1'b0;
      sram_rd_en_o      = 1'b0;
      sram_addr_o       = '0;
      sram_wr_data_o    = '0;
      sram_wr_mask_en_o = 1'b0;
      sram_wr_mask_o    = '0;
      if (wr_strobe) begin
         sram_wr_en_o      = 1'b1;
         sram_addr_o       = addr_index(aw_addr);
         sram_wr_data_o    = w_data;
         sram_wr_mask_en_o = (w_strb != '1);
         sram_wr_mask_o    = w_strb;
      end else if (rd_strobe) begin
         sram_rd_en_o = 1'b1;
         sram_addr_o  = addr_index(ar_addr);
      end
      sram_chip_en_o = sram_wr_en_o | sram_rd_en_o;
   end

   assign s_bresp = bresp;
   assign s_rresp = rresp;
   assign s_rdata = rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_en <= 1'b0;
         last_wr  <= 1'b1;
         aw_cap   <= 1'b0;
         w_cap    <= 1'b0;
         bresp    <= RESP_OKAY;
         rresp    <= RESP_OKAY;
         rdata    <= '0;
      end else begin
         ready_en <= 1'b1;
         if (ar_hs) begin
            last_wr <= 1'b0;
         end else if (wr_go) begin
            last_wr <= 1'b1;
            aw_cap  <= 1'b0;
            w_cap   <= 1'b0;
         end else begin
            if (aw_hs) aw_cap <= 1'b1;
            if (w_hs)  w_cap  <= 1'b1;
         end
         if (state == ST_WR_EXEC) bresp <= wr_err ? RESP_DECERR : RESP_OKAY;
         if (state == ST_RD_EXEC) begin
            rresp <= rd_err ? RESP_DECERR : RESP_OKAY;
            rdata <= rd_err ? '0 : sram_rd_data_i;
         end
      end
   end

   // Request payloads are only meaningful alongside their capture flags.
   always_ff @(posedge clk) begin
      if (aw_hs) aw_addr <= s_awaddr;
      if (ar_hs) ar_addr <= s_araddr;
      if (w_hs) begin
         w_data <= s_wdata;
         w_strb <= s_wstrb;
      end
   end

endmodule

// File: tb/tb_sram_axil_ctrl.sv
// Scoreboard bench for sram_axil_ctrl with an attached behavioural SRAM macro.
module tb_sram_axil_ctrl;

   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] s_awaddr = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [63:0] s_wdata = '0;
   logic [7:0]  s_wstrb = '0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;
   logic [31:0] s_araddr = '0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [63:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;
   logic        sram_chip_en_o, sram_wr_en_o, sram_rd_en_o;
   logic [8:0]  sram_addr_o;
   logic [63:0] sram_wr_data_o;
   logic        sram_wr_mask_en_o;
   logic [7:0]  sram_wr_mask_o;
   logic [63:0] sram_rd_data_i;

   always #5 clk = ~clk;

   sram_axil_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .sram_chip_en_o(sram_chip_en_o), .sram_wr_en_o(sram_wr_en_o), .sram_rd_en_o(sram_rd_en_o),
      .sram_addr_o(sram_addr_o), .sram_wr_data_o(sram_wr_data_o),
      .sram_wr_mask_en_o(sram_wr_mask_en_o), .sram_wr_mask_o(sram_wr_mask_o),
      .sram_rd_data_i(sram_rd_data_i)
   );

   // SRAM macro: asynchronous read, synchronous masked write.
   logic [63:0] sram_mem [DEPTH] = '{default: '0};
   assign sram_rd_data_i = sram_mem[sram_addr_o];
   always @(posedge clk) begin
      if (sram_chip_en_o && sram_wr_en_o)
         for (int b = 0; b < 8; b++)
            if (!sram_wr_mask_en_o || sram_wr_mask_o[b])
               sram_mem[sram_addr_o][8*b +: 8] <= sram_wr_data_o[8*b +: 8];
   end

   typedef struct packed {
      logic        is_wr;
      logic [1:0]  resp;
      logic [63:0] data;
   } resp_t;

   typedef struct packed {
      logic        is_wr;
      logic [8:0]  idx;
      logic [63:0] data;
      logic        mask_en;
      logic [7:0]  mask;
   } strobe_t;

   resp_t       resp_q[$];
   strobe_t     strb_q[$];
   logic [63:0] ref_mem [DEPTH] = '{default: '0};
   logic        ref_last_wr = 1'b1;
   int          n_chk = 0;
   int          n_fail = 0;
   int          rsp_mode = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: address map and byte-merge computed from the address rules.
   function automatic logic addr_bad(input logic [31:0] a);
      return a >= 32'h0000_1000;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      int idx;
      idx = int'(a / 8);
      resp_q.push_back('{is_wr: 1'b1, resp: addr_bad(a) ? 2'b11 : 2'b00, data: 64'h0});
      if (!addr_bad(a) && s != 8'h00) begin
         strb_q.push_back('{is_wr: 1'b1, idx: 9'(idx), data: d, mask_en: (s != 8'hFF), mask: s});
         for (int b = 0; b < 8; b++)
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end
      ref_last_wr = 1'b1;
   endtask

   task automatic model_read(input logic [31:0] a);
      int idx;
      idx = int'(a / 8);
      if (addr_bad(a)) begin
         resp_q.push_back('{is_wr: 1'b0, resp: 2'b11, data: 64'h0});
      end else begin
         resp_q.push_back('{is_wr: 1'b0, resp: 2'b00, data: ref_mem[idx]});
         strb_q.push_back('{is_wr: 1'b0, idx: 9'(idx), data: 64'h0, mask_en: 1'b0, mask: 8'h00});
      end
      ref_last_wr = 1'b0;
   endtask

   task automatic send_aw(input logic [31:0] a, input int dly);
      int n = 0;
      repeat (dly) begin @(posedge clk); #1; end
      s_awaddr = a; s_awvalid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_awready) break;
         if (++n > 100) begin chk("aw_handshake_timeout", 64'd0, 64'd1); break; end
      end
      @(posedge clk); #1;
      s_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] d, input logic [7:0] s, input int dly);
      int n = 0;
      repeat (dly) begin @(posedge clk); #1; end
      s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_wready) break;
         if (++n > 100) begin chk("w_handshake_timeout", 64'd0, 64'd1); break; end
      end
      @(posedge clk); #1;
      s_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a);
      int n = 0;
      s_araddr = a; s_arvalid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_arready) break;
         if (++n > 100) begin chk("ar_handshake_timeout", 64'd0, 64'd1); break; end
      end
      @(posedge clk); #1;
      s_arvalid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (resp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
      chk("response_drain", 64'(resp_q.size()), 64'd0);
      #1;
   endtask

   // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
   task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input int lead);
      model_write(a, d, s);
      fork
         send_w(d, s, (lead < 0) ? -lead : 0);
         send_aw(a, (lead > 0) ? lead : 0);
      join
      wait_drain();
   endtask

   task automatic do_read(input logic [31:0] a);
      model_read(a);
      send_ar(a);
      wait_drain();
   endtask

   // AR and AW+W presented in the same cycle; the type not served last goes first.
   task automatic do_both(input logic [31:0] ra, input logic [31:0] wa, input logic [63:0] d, input logic [7:0] s);
      if (ref_last_wr) begin
         model_read(ra); model_write(wa, d, s);
      end else begin
         model_write(wa, d, s); model_read(ra);
      end
      fork
         send_ar(ra);
         send_aw(wa, 0);
         send_w(d, s, 0);
      join
      wait_drain();
   endtask

   initial begin
      s_bready = 1'b1; s_rready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rsp_mode)
            0: begin s_bready = 1'b1; s_rready = 1'b1; end
            1: begin s_bready = ($urandom % 4) != 0; s_rready = ($urandom % 4) != 0; end
            default: begin s_bready = 1'b0; s_rready = 1'b0; end
         endcase
      end
   end

   // Monitor: strobe and response checks, latencies and hold-while-stalled.
   int          ar_cyc = -100, wh_cyc = -100;
   logic        prev_bv = 1'b0, prev_br = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
   logic [1:0]  prev_bresp = '0, prev_rresp = '0;
   logic [63:0] prev_rdata = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         ar_cyc = -100; wh_cyc = -100;
         prev_bv = 1'b0; prev_br = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0;
      end else begin
         if (s_arvalid && s_arready) ar_cyc = cyc;
         if ((s_awvalid && s_awready) || (s_wvalid && s_wready)) wh_cyc = cyc;
         chk("chip_en_vs_strobes", 64'(sram_chip_en_o), 64'(sram_rd_en_o | sram_wr_en_o));
         if (sram_chip_en_o) begin
            if (strb_q.size() == 0) begin
               chk("unexpected_sram_strobe", 64'd1, 64'd0);
            end else begin
               strobe_t e;
               e = strb_q.pop_front();
               chk("sram_wr_en", 64'(sram_wr_en_o), 64'(e.is_wr));
               chk("sram_addr", 64'(sram_addr_o), 64'(e.idx));
               chk("sram_wr_data", sram_wr_data_o, e.data);
               chk("sram_mask_en", 64'(sram_wr_mask_en_o), 64'(e.mask_en));
               chk("sram_mask", 64'(sram_wr_mask_o), 64'(e.mask));
               chk("strobe_latency", 64'(cyc), 64'((e.is_wr ? wh_cyc : ar_cyc) + 1));
            end
         end else begin
            chk("sram_idle_zero", 64'((|sram_addr_o) | (|sram_wr_data_o) | sram_wr_mask_en_o | (|sram_wr_mask_o)), 64'd0);
         end
         if (s_bvalid && !prev_bv) chk("bvalid_latency", 64'(cyc), 64'(wh_cyc + 2));
         if (s_rvalid && !prev_rv) chk("rvalid_latency", 64'(cyc), 64'(ar_cyc + 2));
         if (prev_bv && !prev_br) begin
            chk("bvalid_hold", 64'(s_bvalid), 64'd1);
            chk("bresp_hold", 64'(s_bresp), 64'(prev_bresp));
         end
         if (prev_rv && !prev_rr) begin
            chk("rvalid_hold", 64'(s_rvalid), 64'd1);
            chk("rdata_hold", s_rdata, prev_rdata);
         end
         if (s_bvalid && s_bready) begin
            if (resp_q.size() == 0) chk("unexpected_b", 64'd1, 64'd0);
            else begin
               resp_t e;
               e = resp_q.pop_front();
               chk("order_b_is_write", 64'(e.is_wr), 64'd1);
               chk("bresp", 64'(s_bresp), 64'(e.resp));
            end
         end
         if (s_rvalid && s_rready) begin
            if (resp_q.size() == 0) chk("unexpected_r", 64'd1, 64'd0);
            else begin
               resp_t e;
               e = resp_q.pop_front();
               chk("order_r_is_read", 64'(e.is_wr), 64'd0);
               chk("rresp", 64'(s_rresp), 64'(e.resp));
               chk("rdata", s_rdata, e.data);
            end
         end
         prev_bv = s_bvalid; prev_br = s_bready; prev_bresp = s_bresp;
         prev_rv = s_rvalid; prev_rr = s_rready; prev_rdata = s_rdata;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arready", 64'(s_arready), 64'd0);
      chk("rst_awready", 64'(s_awready), 64'd0);
      chk("rst_wready", 64'(s_wready), 64'd0);
      chk("rst_bvalid", 64'(s_bvalid), 64'd0);
      chk("rst_rvalid", 64'(s_rvalid), 64'd0);
      chk("rst_resps", 64'({s_bresp, s_rresp}), 64'd0);
      chk("rst_rdata", s_rdata, 64'd0);
      chk("rst_sram", 64'({sram_chip_en_o, sram_wr_en_o, sram_rd_en_o, sram_addr_o}), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_arready", 64'(s_arready), 64'd1);
      chk("post_rst_awready", 64'(s_awready), 64'd1);
      chk("post_rst_wready", 64'(s_wready), 64'd1);

      do_write(32'h10, 64'h1122334455667788, 8'hFF, 0);
      do_read(32'h10);
      do_write(32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0);
      do_read(32'h13);
      do_write(32'h28, 64'hCAFEF00DDEADBEEF, 8'hFF, 3);
      do_both(32'h28, 32'h30, 64'h0102030405060708, 8'hF0);
      do_both(32'h30, 32'h38, 64'h99887766554433CC, 8'h3C);
      do_read(32'h38);
      do_read(32'h1000);
      do_write(32'h1000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0);
      do_read(32'h8000_0010);
      do_write(32'h40, 64'h5555555555555555, 8'h00, -2);
      do_read(32'h40);
      do_read(32'h0FF8);

      // Stalled write response interrupted by reset; SRAM contents must survive.
      rsp_mode = 2;
      @(posedge clk); #1;
      model_write(32'h50, 64'h0BADC0DE12345678, 8'hFF);
      fork
         send_aw(32'h50, 0);
         send_w(64'h0BADC0DE12345678, 8'hFF, 0);
      join
      n = 0;
      while (!s_bvalid && n < 20) begin @(posedge clk); #1; n++; end
      chk("stall_bvalid_seen", 64'(s_bvalid), 64'd1);
      repeat (5) begin @(posedge clk); #1; end
      chk("stall_bvalid_held", 64'(s_bvalid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_bvalid", 64'(s_bvalid), 64'd0);
      chk("async_rst_readies", 64'({s_arready, s_awready, s_wready}), 64'd0);
      resp_q.delete();
      ref_last_wr = 1'b1;
      chk("rst_no_pending_strobe", 64'(strb_q.size()), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      rsp_mode = 0;
      @(posedge clk); #1;
      chk("rel_arready", 64'(s_arready), 64'd1);
      chk("rel_awready", 64'(s_awready), 64'd1);
      do_read(32'h50);

      rsp_mode = 1;
      for (int i = 0; i < 80; i++) begin
         logic [31:0] a1, a2;
         logic [63:0] d;
         logic [7:0]  s;
         int          pick;
         for (int k = 0; k < 2; k++) begin
            logic [31:0] a;
            pick = int'($urandom % 10);
            if (pick == 0)      a = 32'h1000 + ($urandom % 32'h1000);
            else if (pick == 1) a = $urandom | 32'h8000_0000;
            else if (pick == 2) a = (32'($urandom_range(500, 511)) << 3) | ($urandom % 8);
            else                a = (32'($urandom_range(0, 15)) << 3) | ($urandom % 8);
            if (k == 0) a1 = a; else a2 = a;
         end
         d = {$urandom, $urandom};
         s = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
         case ($urandom % 3)
            0:       do_read(a1);
            1:       do_write(a1, d, s, int'($urandom_range(0, 4)) - 2);
            default: do_both(a1, a2, d, s);
         endcase
      end
      rsp_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("final_strobe_queue_empty", 64'(strb_q.size()), 64'd0);
      chk("final_resp_queue_empty", 64'(resp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
